// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and width helpers for the cache-line to pmem burst adaptor.
package cacheline_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Width of one pmem beat.
  function automatic int burst_width(input int line_w, input int len);
    return line_w / len;
  endfunction

  // Number of byte-offset bits inside one cache line.
  function automatic int offset_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Beat counter width (at least one bit).
  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  localparam int DEF_LINE_W    = 256;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_BEAT_W    = burst_width(DEF_LINE_W, DEF_BURST_LEN);

  typedef logic [DEF_LINE_W-1:0] line_t;
  typedef logic [DEF_BEAT_W-1:0] beat_t;

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-side and pmem-side signals of the adaptor. The slave modport is the
// adaptor itself; the master modport is its environment (cache + pmem).
interface cacheline_burst_adaptor_if #(
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int BURST_LEN        = 4,
  parameter int ADDR_WIDTH       = 32
);
  import cacheline_adaptor_pkg::*;

  localparam int BURST_WIDTH = burst_width(CACHE_LINE_WIDTH, BURST_LEN);

  // Cache side
  logic [CACHE_LINE_WIDTH-1:0] line_i;
  logic [CACHE_LINE_WIDTH-1:0] line_o;
  logic [ADDR_WIDTH-1:0]       address_i;
  logic                        read_i;
  logic                        write_i;
  logic                        resp_o;
  // pmem side
  logic [ADDR_WIDTH-1:0]       pmem_addr_o;
  logic                        pmem_read_o;
  logic                        pmem_write_o;
  logic [BURST_WIDTH-1:0]      pmem_rdata_i;
  logic [BURST_WIDTH-1:0]      pmem_wdata_o;
  logic                        pmem_resp_i;
  // Status
  logic                        err_o;

  modport master (
    output line_i, address_i, read_i, write_i, pmem_rdata_i, pmem_resp_i,
    input  line_o, resp_o, pmem_addr_o, pmem_read_o, pmem_write_o, pmem_wdata_o, err_o
  );

  modport slave (
    input  line_i, address_i, read_i, write_i, pmem_rdata_i, pmem_resp_i,
    output line_o, resp_o, pmem_addr_o, pmem_read_o, pmem_write_o, pmem_wdata_o, err_o
  );

endinterface

// File: rtl/cacheline_burst_adaptor_buffer.sv
// Line buffer: one cache line of storage with a full-line load port, a
// beat-indexed write port and a beat-indexed read mux.
module burst_line_buffer #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              beat_we_i,
  input  logic [IDX_W-1:0]  beat_idx_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic [LINE_W-1:0] line_o,
  output logic [BEAT_W-1:0] beat_o
);

  logic [LINE_W-1:0] line_q, line_d;

  // Next line contents: full load wins over a single-beat capture.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (beat_we_i) begin
      line_d[beat_idx_i*BEAT_W +: BEAT_W] = beat_i;
    end
  end

  // Line storage; cleared on reset so line_o and pmem_wdata_o start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this storage is reset on purpose (defined outputs after reset); sequential state uses <= only.
    if (!rst_n) line_q <= '0;
    else        line_q <= line_d;
  end

  assign line_o = line_q;
  assign beat_o = line_q[beat_idx_i*BEAT_W +: BEAT_W];

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Converts single-cycle cache line fills/write-backs into BURST_LEN-beat pmem
// bursts. Optional watchdog enabled by defining CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_burst_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int BURST_LEN        = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input logic                        clk,
  input logic                        rst_n,
  cacheline_burst_adaptor_if.slave   bus
);

  localparam int BURST_WIDTH = burst_width(CACHE_LINE_WIDTH, BURST_LEN);
  localparam int OFFSET_BITS = offset_bits(CACHE_LINE_WIDTH);
  localparam int CNT_W       = cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    buf_load, beat_we, last_beat, timeout_hit;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;

  // Watchdog: counts burst cycles since the last beat; expiry forces DONE.
  always_comb begin
    timer_d     = '0;
    err_d       = err_q;
    timeout_hit = 1'b0;
    if ((state_q == RD_BURST || state_q == WR_BURST) && !bus.pmem_resp_i) begin
      if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit = 1'b1;
        err_d       = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.err_o   = 1'b0;
`endif

  // Next-state, beat counter and request decode.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    buf_load         = 1'b0;
    beat_we          = 1'b0;
    bus.pmem_read_o  = 1'b0;
    bus.pmem_write_o = 1'b0;
    bus.resp_o       = 1'b0;
    last_beat        = (cnt_q == LAST_BEAT);
    case (state_q)
      IDLE: begin
        if (bus.write_i) begin
          addr_d   = bus.address_i & ALIGN_MASK;
          buf_load = 1'b1;
          state_d  = WR_BURST;
        end else if (bus.read_i) begin
          addr_d  = bus.address_i & ALIGN_MASK;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        bus.pmem_read_o = 1'b1;
        if (bus.pmem_resp_i) begin
          beat_we = 1'b1;
          cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end else if (timeout_hit) begin
          state_d = DONE;
        end
      end
      WR_BURST: begin
        bus.pmem_write_o = 1'b1;
        if (bus.pmem_resp_i) begin
          cnt_d = last_beat ? '0 : cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end else if (timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.resp_o = 1'b1;
        cnt_d      = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, beat counter and latched line address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.pmem_addr_o = addr_q;

  burst_line_buffer #(
    .LINE_W (CACHE_LINE_WIDTH),
    .BEAT_W (BURST_WIDTH),
    .IDX_W  (CNT_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (buf_load),
    .line_i     (bus.line_i),
    .beat_we_i  (beat_we),
    .beat_idx_i (cnt_q),
    .beat_i     (bus.pmem_rdata_i),
    .line_o     (bus.line_o),
    .beat_o     (bus.pmem_wdata_o)
  );

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench for cacheline_burst_adaptor: directed and randomized
// line transactions against a behavioural pmem and expected-line model.
module tb_cacheline_burst_adaptor;
  import cacheline_adaptor_pkg::*;

  localparam int LW = 256;
  localparam int BL = 4;
  localparam int AW = 32;
  localparam int BW = LW / BL;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cacheline_burst_adaptor_if #(.CACHE_LINE_WIDTH(LW), .BURST_LEN(BL), .ADDR_WIDTH(AW)) bus ();

  cacheline_burst_adaptor #(
    .CACHE_LINE_WIDTH (LW),
    .BURST_LEN        (BL),
    .ADDR_WIDTH       (AW),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    bus.pmem_resp_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cache transaction against a pmem model that waits 'delay' request
  // cycles, then returns beats, pausing 'gap_len' cycles after beat 'gap_at'.
  task automatic txn(input string name, input bit do_wr, input bit do_rd,
                     input logic [AW-1:0] addr, input line_t wline, input line_t rline,
                     input int delay, input int gap_at, input int gap_len);
    logic [AW-1:0] exp_addr;
    line_t exp_line, got_w;
    int beats, req_cyc, gap_left, rd_hi, wr_hi, resp_cyc, exp_resp, eff_gap;
    bit seen;
    logic [1:0] exp_req;
    exp_addr = addr & ~AW'(LW / 8 - 1);
    exp_line = do_wr ? wline : rline;
    exp_req  = do_wr ? 2'b10 : 2'b01;
    eff_gap  = (gap_at >= 0 && gap_at < BL - 1) ? gap_len : 0;
    exp_resp = delay + BL + eff_gap + 1;
    beats = 0; req_cyc = 0; gap_left = 0; rd_hi = 0; wr_hi = 0; resp_cyc = -1;
    seen = 1'b0; got_w = '0;
    @(negedge clk);
    bus.address_i = addr;
    bus.line_i = wline;
    bus.write_i = do_wr;
    bus.read_i = do_rd;
    bus.pmem_resp_i = 1'b0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      @(negedge clk);
      bus.pmem_resp_i = 1'b0;
      if (bus.resp_o) begin
        seen = 1'b1;
        resp_cyc = c;
        n_cmp++;
        if (resp_cyc !== exp_resp) begin
          n_bad++; $display("FAIL %s resp_cycle: got %0d want %0d", name, resp_cyc, exp_resp);
        end
        n_cmp++;
        if ({bus.pmem_write_o, bus.pmem_read_o} !== 2'b00) begin
          n_bad++; $display("FAIL %s done_req: got %b want 00", name, {bus.pmem_write_o, bus.pmem_read_o});
        end
        n_cmp++;
        if (bus.line_o !== exp_line) begin
          n_bad++; $display("FAIL %s line_o: got %h want %h", name, bus.line_o, exp_line);
        end
        bus.read_i = 1'b0;
        bus.write_i = 1'b0;
      end else if (bus.pmem_read_o || bus.pmem_write_o) begin
        req_cyc++;
        if (bus.pmem_read_o) rd_hi++;
        if (bus.pmem_write_o) wr_hi++;
        n_cmp++;
        if (bus.pmem_addr_o !== exp_addr) begin
          n_bad++; $display("FAIL %s pmem_addr c%0d: got %h want %h", name, c, bus.pmem_addr_o, exp_addr);
        end
        n_cmp++;
        if ({bus.pmem_write_o, bus.pmem_read_o} !== exp_req) begin
          n_bad++; $display("FAIL %s req_kind c%0d: got %b want %b", name, c, {bus.pmem_write_o, bus.pmem_read_o}, exp_req);
        end
        if (gap_left > 0) begin
          gap_left--;
        end else if (req_cyc > delay && beats < BL) begin
          bus.pmem_resp_i = 1'b1;
          bus.pmem_rdata_i = rline[beats*BW +: BW];
          if (do_wr) got_w[beats*BW +: BW] = bus.pmem_wdata_o;
          if (beats == gap_at) gap_left = gap_len;
          beats++;
        end
      end
      // Accepted requests ignore later changes to the cache-side inputs.
      bus.address_i = $urandom;
      bus.line_i = rand_line();
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL %s no_resp: got none want pulse at %0d", name, exp_resp);
      pulse_reset();
    end
    n_cmp++;
    if (rd_hi !== (do_wr ? 0 : exp_resp - 1)) begin
      n_bad++; $display("FAIL %s read_hi_cycles: got %0d want %0d", name, rd_hi, do_wr ? 0 : exp_resp - 1);
    end
    n_cmp++;
    if (wr_hi !== (do_wr ? exp_resp - 1 : 0)) begin
      n_bad++; $display("FAIL %s write_hi_cycles: got %0d want %0d", name, wr_hi, do_wr ? exp_resp - 1 : 0);
    end
    if (do_wr) begin
      n_cmp++;
      if (got_w !== wline) begin
        n_bad++; $display("FAIL %s mem_contents: got %h want %h", name, got_w, wline);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.resp_o, bus.pmem_write_o, bus.pmem_read_o} !== 3'b000) begin
      n_bad++; $display("FAIL %s after_done: got %b want 000", name, {bus.resp_o, bus.pmem_write_o, bus.pmem_read_o});
    end
  endtask

  task automatic test_reset();
    bus.read_i = 1'b0; bus.write_i = 1'b0; bus.pmem_resp_i = 1'b0;
    bus.address_i = '0; bus.line_i = '0; bus.pmem_rdata_i = '0;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({bus.resp_o, bus.pmem_read_o, bus.pmem_write_o, bus.err_o} !== 4'b0000 ||
        bus.pmem_addr_o !== '0 || bus.pmem_wdata_o !== '0 || bus.line_o !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got resp/rd/wr/err=%b addr=%h wdata=%h", {bus.resp_o, bus.pmem_read_o, bus.pmem_write_o, bus.err_o}, bus.pmem_addr_o, bus.pmem_wdata_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_basic();
    line_t l;
    l = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    txn("read_basic", 1'b0, 1'b1, 32'h0000_1234, rand_line(), l, 5, -1, 0);
  endtask

  task automatic test_write_basic();
    line_t l;
    l = {64'h4, 64'h3, 64'h2, 64'h1};
    txn("write_basic", 1'b1, 1'b0, 32'h0000_8040, l, rand_line(), 2, -1, 0);
  endtask

  task automatic test_both_requests();
    txn("write_wins", 1'b1, 1'b1, 32'hABCD_EF17, rand_line(), rand_line(), 1, -1, 0);
  endtask

  task automatic test_resp_gap();
    txn("read_gap", 1'b0, 1'b1, 32'h1000_00FF, rand_line(), rand_line(), 2, 1, 3);
    txn("write_gap", 1'b1, 1'b0, 32'h2000_0020, rand_line(), rand_line(), 0, 1, 3);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    bus.address_i = 32'h0000_5555; bus.read_i = 1'b1; bus.write_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bus.pmem_resp_i = 1'b1;
      bus.pmem_rdata_i = {$urandom, $urandom};
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.resp_o, bus.pmem_read_o, bus.pmem_write_o} !== 3'b000 ||
        bus.pmem_addr_o !== '0 || bus.line_o !== '0) begin
      n_bad++; $display("FAIL reset_mid_burst: got resp/rd/wr=%b addr=%h line=%h want zeros", {bus.resp_o, bus.pmem_read_o, bus.pmem_write_o}, bus.pmem_addr_o, bus.line_o);
    end
    bus.read_i = 1'b0; bus.pmem_resp_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.resp_o, bus.pmem_read_o} !== 2'b00) begin
        n_bad++; $display("FAIL reset_no_resp c%0d: got %b want 00", c, {bus.resp_o, bus.pmem_read_o});
      end
    end
    txn("read_after_reset", 1'b0, 1'b1, 32'h0000_5555, rand_line(), rand_line(), 3, -1, 0);
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 12; i++) begin
      bit wr, rd;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      txn($sformatf("random%0d", i), wr, rd, $urandom, rand_line(), rand_line(),
          $urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  task automatic test_timeout();
    int resp_cyc, pulses;
    bit err_seen;
    resp_cyc = -1; pulses = 0; err_seen = 1'b0;
    @(negedge clk);
    bus.address_i = 32'h0000_0400; bus.read_i = 1'b1; bus.write_i = 1'b0; bus.pmem_resp_i = 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    for (int c = 1; c <= 60 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (bus.resp_o) begin
        resp_cyc = c;
        n_cmp++;
        if (bus.err_o !== 1'b1) begin
          n_bad++; $display("FAIL timeout_err: got %b want 1", bus.err_o);
        end
        bus.read_i = 1'b0;
      end
    end
    n_cmp++;
    if (resp_cyc !== TMO + 1) begin
      n_bad++; $display("FAIL timeout_resp_cycle: got %0d want %0d", resp_cyc, TMO + 1);
    end
    bus.read_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.err_o, bus.resp_o} !== 2'b10) begin
      n_bad++; $display("FAIL timeout_sticky: got err/resp=%b want 10", {bus.err_o, bus.resp_o});
    end
    pulse_reset();
    n_cmp++;
    if (bus.err_o !== 1'b0) begin
      n_bad++; $display("FAIL timeout_err_cleared: got %b want 0", bus.err_o);
    end
`else
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.resp_o) pulses++;
      if (bus.err_o) err_seen = 1'b1;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL no_timeout_resp: got %0d pulses want 0", pulses);
    end
    n_cmp++;
    if (err_seen !== 1'b0) begin
      n_bad++; $display("FAIL no_timeout_err: got %b want 0", err_seen);
    end
    n_cmp++;
    if (bus.pmem_read_o !== 1'b1) begin
      n_bad++; $display("FAIL still_waiting: got pmem_read_o=%b want 1", bus.pmem_read_o);
    end
    pulse_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_both_requests();
    test_resp_gap();
    test_reset_mid_burst();
    test_back_to_back_random();
    test_timeout();
    txn("read_after_timeout", 1'b0, 1'b1, 32'h0000_0400, rand_line(), rand_line(), 1, -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
